// File: rtl/operand_stack_if.sv
// ============================================================================
//  Module      : operand_stack_if
//  Description : Command/data bundle between the stack-machine control unit
//                and the operand stack. The control side (master) issues
//                commands and supplies push data and the ALU result; the
//                stack side (slave) returns the top two entries, the
//                occupancy and the sticky error flags.
//  Signals     : cmd, push_data, alu_result, clr_err    (master -> slave)
//                tos, nos, count, empty, full,
//                overflow_err, underflow_err            (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_stack_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [1:0]        cmd;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] alu_result;
    logic              clr_err;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] nos;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output cmd,
        output push_data,
        output alu_result,
        output clr_err,
        input  tos,
        input  nos,
        input  count,
        input  empty,
        input  full,
        input  overflow_err,
        input  underflow_err
    );

    modport slave (
        input  cmd,
        input  push_data,
        input  alu_result,
        input  clr_err,
        output tos,
        output nos,
        output count,
        output empty,
        output full,
        output overflow_err,
        output underflow_err
    );
endinterface

`default_nettype wire

// File: rtl/operand_stack.sv
// ============================================================================
//  Module      : operand_stack
//  Description : LIFO operand stack feeding the ALU. NOS drives the first ALU
//                operand and TOS the second, so non-commutative operations
//                compute NOS op TOS. Supports PUSH, POP and REDUCE (pop two,
//                push the ALU result) at one command per cycle, and reports
//                occupancy plus sticky overflow/underflow errors.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - operand_stack_if.slave (command in, tos/nos/count/
//                        empty/full/error flags out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stack #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    operand_stack_if.slave      bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] c_CMD_NOP    = 2'b00;
    localparam logic [1:0] c_CMD_PUSH   = 2'b01;
    localparam logic [1:0] c_CMD_POP    = 2'b10;
    localparam logic [1:0] c_CMD_REDUCE = 2'b11;

    localparam logic [ADDR_W:0] c_ZERO  = '0;
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] c_TWO   = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_count;
    logic              r_overflow_err;
    logic              r_underflow_err;

    // ------------------------------------------------------------------------
    // Index arithmetic. count-1 / count-2 are formed at full count width so
    // that an empty or single-entry stack never aliases onto a high index;
    // the results are only used when the corresponding entry exists, at
    // which point the MSB is always zero and can be dropped.
    // ------------------------------------------------------------------------
    logic [ADDR_W:0]   w_count_m1;
    logic [ADDR_W:0]   w_count_m2;
    logic [ADDR_W-1:0] w_tos_idx;
    logic [ADDR_W-1:0] w_nos_idx;
    logic [ADDR_W-1:0] w_push_idx;
    logic              w_unused_idx_msbs;

    assign w_count_m1        = r_count - c_ONE;
    assign w_count_m2        = r_count - c_TWO;
    assign w_tos_idx         = w_count_m1[ADDR_W-1:0];
    assign w_nos_idx         = w_count_m2[ADDR_W-1:0];
    // A push only happens while not full, so count itself fits in ADDR_W bits.
    assign w_push_idx        = r_count[ADDR_W-1:0];
    assign w_unused_idx_msbs = w_count_m1[ADDR_W] ^ w_count_m2[ADDR_W] ^ r_count[ADDR_W];

    // ------------------------------------------------------------------------
    // Occupancy predicates
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_has_one;
    logic w_has_two;

    assign w_empty   = (r_count == c_ZERO);
    assign w_full    = (r_count == c_DEPTH);
    assign w_has_one = (r_count >= c_ONE);
    assign w_has_two = (r_count >= c_TWO);

    // ------------------------------------------------------------------------
    // Command decode into legal operations and error events. Exactly one of
    // these can be active in a cycle because the command is a single
    // encoded field.
    // ------------------------------------------------------------------------
    logic w_push_ok;
    logic w_pop_ok;
    logic w_reduce_ok;
    logic w_overflow_evt;
    logic w_underflow_evt;

    always_comb begin
        w_push_ok       = 1'b0;
        w_pop_ok        = 1'b0;
        w_reduce_ok     = 1'b0;
        w_overflow_evt  = 1'b0;
        w_underflow_evt = 1'b0;
        case (bus.cmd)
            c_CMD_PUSH: begin
                w_push_ok      = !w_full;
                w_overflow_evt = w_full;
            end
            c_CMD_POP: begin
                w_pop_ok        = w_has_one;
                w_underflow_evt = !w_has_one;
            end
            c_CMD_REDUCE: begin
                w_reduce_ok     = w_has_two;
                w_underflow_evt = !w_has_two;
            end
            c_CMD_NOP: begin
                // no operation
            end
            default: begin
                // all encodings covered above
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Count and sticky error flags. Set has priority over clear so an error
    // raised in the same cycle as clr_err is never lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count         <= c_ZERO;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_count <= r_count + c_ONE;
            end else if (w_pop_ok || w_reduce_ok) begin
                r_count <= w_count_m1;
            end

            if (w_overflow_evt) begin
                r_overflow_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow_err <= 1'b0;
            end

            if (w_underflow_evt) begin
                r_underflow_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage array. Contents are deliberately not reset; validity is carried
    // entirely by r_count. Writes are gated by rst_n so commands issued while
    // reset is held cannot disturb the array.
    // A REDUCE overwrites the NOS slot with the ALU result; the old TOS slot
    // simply falls outside the valid range when count decrements.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_push_ok) begin
                r_mem[w_push_idx] <= bus.push_data;
            end else if (w_reduce_ok) begin
                r_mem[w_nos_idx] <= bus.alu_result;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. tos/nos read straight from the array so the ALU sees the new
    // operands in the cycle after the command, enabling back-to-back REDUCE.
    // ------------------------------------------------------------------------
    assign bus.tos           = w_has_one ? r_mem[w_tos_idx] : '0;
    assign bus.nos           = w_has_two ? r_mem[w_nos_idx] : '0;
    assign bus.count         = r_count;
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;
    assign bus.overflow_err  = r_overflow_err;
    assign bus.underflow_err = r_underflow_err;

endmodule

`default_nettype wire

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware LIFO operand stack for the stack-machine datapath; sits directly upstream of the ALU.
- Drives the ALU operand inputs:
  - NOS (next-of-stack) goes to the first operand.
  - TOS (top-of-stack) goes to the second operand.
  - So SUB/SLT compute NOS op TOS.
- Accepts push, pop and reduce commands; reduce pops two entries and pushes the ALU result in one cycle.
- Reports occupancy and sticky overflow/underflow errors to control.

Parameters:
- DATA_W, 32, operand width; matches the ALU datapath.
- ADDR_W, 4, stack index width; DEPTH = 2**ADDR_W entries (16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd  input  2  command: 00 NOP, 01 PUSH, 10 POP, 11 REDUCE.
- push_data  input  DATA_W  value written on PUSH.
- alu_result  input  DATA_W  ALU result written on REDUCE.
- clr_err  input  1  clears sticky error flags.
- tos  output  DATA_W  top entry; 0 when count==0.
- nos  output  DATA_W  entry below top; 0 when count<2.
- count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow_err  output  1  sticky; PUSH attempted while full.
- underflow_err  output  1  sticky; POP with count<1 or REDUCE with count<2.

Behaviour:
- Storage:
  - DEPTH x DATA_W register array; entry i is valid for i<count.
  - Array contents are not reset.
- tos/nos:
  - Combinational from count and array: tos = mem[count-1], nos = mem[count-2].
  - Forced to 0 when the entry is absent.
  - An update is visible the cycle after the command edge.
- Reset (rst_n low, asynchronous, any time including mid-command):
  - count=0, overflow_err=0, underflow_err=0.
  - Hence empty=1, full=0, tos=0, nos=0 immediately.
  - Commands are ignored while rst_n is low.
  - The first command is accepted on the first rising edge after deassertion.
- PUSH:
  - If count<DEPTH: mem[count]<=push_data, count<=count+1.
  - If full: no state change, overflow_err<=1.
- POP:
  - If count>=1: count<=count-1; the popped value is the tos presented during the POP cycle.
  - If count==0: no change, underflow_err<=1.
- REDUCE:
  - If count>=2: mem[count-2]<=alu_result, count<=count-1.
  - alu_result is the combinational ALU output of the current tos/nos, so one REDUCE per cycle is allowed back-to-back.
  - If count<2: no change, underflow_err<=1.
- NOP: no state change.
- One command per cycle by encoding; no simultaneous push/pop case exists.
- Pointer saturation:
  - No wrap-around; count never exceeds DEPTH or goes below 0.
  - Illegal commands leave the array and count untouched.
- Error flags:
  - Sticky until clr_err=1 is sampled on an edge.
  - If clr_err coincides with a new error event in the same cycle, the flag is set (set wins).
  - clr_err clears both flags otherwise.
- No internal pipelining:
  - Command-to-count/tos latency is 1 cycle.
  - There is no ready/valid handshake; control must consult full/empty or accept the error flags.
- Widths:
  - count is ADDR_W+1 bits so that DEPTH is representable.
  - Index arithmetic is done at ADDR_W+1 bits before truncation to avoid wrap on count-1/count-2.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, tos=0, nos=0, both errors 0; assert rst_n low mid-run with count=5 -> count=0 asynchronously, before the next clk edge.
- PUSH 0x0000000A then PUSH 0x00000003 -> count=2, nos=0x0A, tos=0x03; REDUCE with alu_result=0x00000007 (SUB) -> count=1, tos=0x07, nos=0.
- 16 PUSHes of values 1..16 -> full=1, tos=16, nos=15; 17th PUSH 0xDEADBEEF -> count stays 16, tos stays 16, overflow_err=1; 16 POPs -> tos sequence 16..1 observed, empty=1.
- Empty: POP -> underflow_err=1, count=0; clr_err -> flags 0; single PUSH 0x5 then REDUCE -> underflow_err=1, count=1, tos=0x5.
- Same cycle clr_err=1 and illegal POP on empty -> underflow_err remains 1; next cycle clr_err with NOP -> 0.
- Back-to-back REDUCE chain: push 1,2,3,4, then 3 REDUCEs with the ALU in ADD mode -> tos after each = 7, 9, 10; count 3, 2, 1.
